// File: rtl/seg_pkg.sv
// Shared definitions for the segment-scan decoder: glyph codes, glyph decode and FSM states.
package seg_pkg;

  // Active-high segment patterns, bit0=a .. bit6=g
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h67;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } fsm_t;

  // Returns {valid, blank, nibble}; valid=0 marks an undecodable glyph.
  function automatic logic [5:0] seg_to_hex(input logic [6:0] p);
    logic [5:0] r;
    r = 6'b0;
    case (p)
      SEG_0:     r = {2'b10, 4'h0};
      SEG_1:     r = {2'b10, 4'h1};
      SEG_2:     r = {2'b10, 4'h2};
      SEG_3:     r = {2'b10, 4'h3};
      SEG_4:     r = {2'b10, 4'h4};
      SEG_5:     r = {2'b10, 4'h5};
      SEG_6:     r = {2'b10, 4'h6};
      SEG_7:     r = {2'b10, 4'h7};
      SEG_8:     r = {2'b10, 4'h8};
      SEG_9:     r = {2'b10, 4'h9};
      SEG_A:     r = {2'b10, 4'hA};
      SEG_B:     r = {2'b10, 4'hB};
      SEG_C:     r = {2'b10, 4'hC};
      SEG_D:     r = {2'b10, 4'hD};
      SEG_E:     r = {2'b10, 4'hE};
      SEG_F:     r = {2'b10, 4'hF};
      SEG_BLANK: r = {2'b11, 4'h0};
      default:   r = 6'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Multiplexed active-low display bus: segment lines plus one-hot-low digit selects.
interface seg_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]            seg_n;
  logic [NUM_DIGITS-1:0] dig_sel_n;

  modport master (output seg_n, output dig_sel_n);
  modport slave  (input  seg_n, input  dig_sel_n);
endinterface

// File: rtl/seg_stable_filter.sv
// Registers the display bus and accepts a segment/select pair once it has been
// stable for STABLE_CYCLES samples; a held pair is accepted only once.
module seg_stable_filter
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_n,
  input  logic [NUM_DIGITS-1:0] dig_sel_n,
  output logic                  accept,
  output logic [6:0]            pattern,
  output logic [2:0]            index
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  logic [6:0]            seg_reg, seg_prev_reg;
  logic [NUM_DIGITS-1:0] sel_reg, sel_prev_reg;
  logic [CW-1:0]         cnt_reg, cnt_next, cnt_inc;
  fsm_t                  state_reg, state_next;
  logic                  accept_reg, accept_next;
  logic [6:0]            pattern_reg;
  logic [2:0]            index_reg, idx_enc;
  logic                  sel_valid, same;

  always_comb begin
    sel_valid = ($countones(~sel_reg) == 1);
    same      = (seg_reg == seg_prev_reg) && (sel_reg == sel_prev_reg);
    cnt_inc   = (cnt_reg == STABLE_C) ? cnt_reg : cnt_reg + 1'b1;
  end

  always_comb begin
    idx_enc = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!sel_reg[i]) idx_enc = 3'(i);
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    accept_next = 1'b0;
    if (!sel_valid) begin
      state_next = SETTLE;
      cnt_next   = '0;
    end else if (!same) begin
      // A fresh sample counts as the first of its run in either state.
      state_next = SETTLE;
      cnt_next   = ONE_C;
      if (ONE_C == STABLE_C) begin
        accept_next = 1'b1;
        state_next  = LOCKED;
      end
    end else begin
      cnt_next = cnt_inc;
      if (state_reg == SETTLE && cnt_inc == STABLE_C) begin
        accept_next = 1'b1;
        state_next  = LOCKED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_reg      <= '0;
      sel_reg      <= '0;
      seg_prev_reg <= '0;
      sel_prev_reg <= '0;
      cnt_reg      <= '0;
      state_reg    <= SETTLE;
      accept_reg   <= 1'b0;
      pattern_reg  <= '0;
      index_reg    <= '0;
    end else begin
      seg_reg      <= seg_n;
      sel_reg      <= dig_sel_n;
      seg_prev_reg <= seg_reg;
      sel_prev_reg <= sel_reg;
      cnt_reg      <= cnt_next;
      state_reg    <= state_next;
      accept_reg   <= accept_next;
      if (accept_next) begin
        pattern_reg <= ~seg_reg;
        index_reg   <= idx_enc;
      end
    end
  end

  assign accept  = accept_reg;
  assign pattern = pattern_reg;
  assign index   = index_reg;

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers hex digits from a multiplexed 7-segment bus and publishes one
// complete frame once every digit position has decoded successfully.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  seg_scan_decoder_if.slave       bus,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   blank_out,
  output logic                    frame_valid,
  output logic                    err,
  output logic [2:0]              err_digit
);

  logic       accept;
  logic [6:0] pattern;
  logic [2:0] index;
  logic [5:0] decode;
  logic       dec_valid, dec_blank;
  logic [3:0] dec_nib;

  logic [4*NUM_DIGITS-1:0] work_dig_reg, work_dig_next;
  logic [NUM_DIGITS-1:0]   work_blank_reg, work_blank_next;
  logic [NUM_DIGITS-1:0]   seen_reg, seen_set, wr;
  logic                    frame_done;

  seg_stable_filter #(
    .NUM_DIGITS   (NUM_DIGITS),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .seg_n    (bus.seg_n),
    .dig_sel_n(bus.dig_sel_n),
    .accept   (accept),
    .pattern  (pattern),
    .index    (index)
  );

  always_comb begin
    decode    = seg_to_hex(pattern);
    dec_valid = decode[5];
    dec_blank = decode[4];
    dec_nib   = decode[3:0];
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign wr[gi] = accept && dec_valid && (index == 3'(gi));
      assign work_dig_next[4*gi +: 4] = wr[gi] ? dec_nib : work_dig_reg[4*gi +: 4];
      assign work_blank_next[gi]      = wr[gi] ? dec_blank : work_blank_reg[gi];
      assign seen_set[gi]             = seen_reg[gi] | wr[gi];
    end
  endgenerate

  // Completion needs a fresh decode, so re-writing a seen digit never closes a frame by itself.
  assign frame_done = accept && dec_valid && (&seen_set);

  always_ff @(posedge clk) begin
    if (rst) begin
      work_dig_reg   <= '0;
      work_blank_reg <= '0;
      seen_reg       <= '0;
      digits_out     <= '0;
      blank_out      <= '0;
      frame_valid    <= 1'b0;
      err            <= 1'b0;
      err_digit      <= '0;
    end else begin
      work_dig_reg   <= work_dig_next;
      work_blank_reg <= work_blank_next;
      seen_reg       <= frame_done ? '0 : seen_set;
      frame_valid    <= frame_done;
      err            <= accept && !dec_valid;
      if (accept && !dec_valid) err_digit <= index;
      if (frame_done) begin
        digits_out <= work_dig_next;
        blank_out  <= work_blank_next;
      end
    end
  end

endmodule
